// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word-aligned load/store at a time.
// Each request waits LATENCY cycles and then commits (store) or reads (load).
// The response is held until the core accepts it.
//
// Handshake rules:
// - A request transfers on a rising edge where req_valid && req_ready.
// - A response transfers on a rising edge where resp_valid && resp_ready.
// - req_ready is high only in IDLE, so at most one request is in flight.
// - resp_rdata and resp_err stay stable while resp_valid is high and
//   resp_ready is low.
module data_mem_responder #(
    parameter int MEMORY_SIZE = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  o_dbg_state
);

    localparam int DEPTH = MEMORY_SIZE / 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    // Request fields captured at acceptance
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic [31:0] r_mem [0:DEPTH-1];

    // The commit uses the live request when it happens on the accepting
    // edge (zero latency) and the captured copy otherwise.
    logic        w_accept;
    logic        w_commit;
    logic        w_c_write;
    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [3:0]  w_c_wstrb;
    logic        w_err;
    logic [AW-1:0] w_idx;

    assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_commit  = (w_accept && (LATENCY == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_c_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_c_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_c_wstrb = (r_state == S_IDLE) ? req_wstrb : r_wstrb;
    // Full 32-bit range check, so high addresses never alias into storage
    assign w_err     = (w_c_addr[1:0] != 2'b00) || (w_c_addr >= 32'(MEMORY_SIZE));
    assign w_idx     = w_c_addr[AW+1:2];

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign o_dbg_state = r_state;

    // Control FSM: acceptance, wait countdown, response hold and release
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        if (LATENCY > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT_M1;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    r_req_ready <= 1'b0;
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
            // The commit edge loads the response registers
            if (w_commit) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || w_c_write) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Storage: cleared on reset, byte-lane merge on an error-free store commit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_commit && w_c_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder.
// Main instance: LATENCY=2, randomized traffic against a word-array model.
// Second instance: LATENCY=0, directed timing checks.
module tb_data_mem_responder;

    localparam int MEM = 256;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        reset = 1'b1;

    // Main DUT signals
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    // Zero-latency DUT signals
    logic        z_valid = 1'b0;
    logic        z_req_ready;
    logic        z_write = 1'b0;
    logic [31:0] z_addr = 32'd0;
    logic [31:0] z_wdata = 32'd0;
    logic [3:0]  z_wstrb = 4'd0;
    logic        z_resp_valid;
    logic [31:0] z_rdata;
    logic        z_err;
    logic [1:0]  z_dbg;

    data_mem_responder #(.MEMORY_SIZE(MEM), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .o_dbg_state(dbg_state)
    );

    data_mem_responder #(.MEMORY_SIZE(MEM), .LATENCY(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_valid), .req_ready(z_req_ready), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_wstrb(z_wstrb),
        .resp_valid(z_resp_valid), .resp_ready(1'b1),
        .resp_rdata(z_rdata), .resp_err(z_err), .o_dbg_state(z_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:MEM/4-1];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_cyc_q[$];

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= MEM);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MEM/4; i++) ref_mem[i] = 32'd0;
        exp_q.delete();
        exp_err_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int acc);
        logic [31:0] rd;
        logic [31:0] word;
        bit bad;
        bad = addr_bad(a);
        rd  = 32'd0;
        if (!bad) begin
            word = ref_mem[a / 4];
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                ref_mem[a / 4] = word;
            end else begin
                rd = word;
            end
        end
        exp_q.push_back(rd);
        exp_err_q.push_back(bad);
        exp_cyc_q.push_back(acc);
    endtask

    // ---------------- response-side driver ----------------
    bit hold_rr = 1'b0;
    bit rr_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        if (hold_rr) resp_ready = 1'b0;
        else if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
        else resp_ready = 1'b1;
    end

    // ---------------- monitor ----------------
    bit          mon_en    = 1'b0;
    bit          in_resp   = 1'b0;
    bit          chk_after = 1'b0;
    logic [31:0] h_rdata;
    logic        h_err;
    logic [31:0] e_rd;
    logic        e_er;
    int          e_cy;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (chk_after) begin
                check("post_hs_resp_valid", 32'(resp_valid), 32'd0);
                check("post_hs_req_ready", 32'(req_ready), 32'd1);
                chk_after = 1'b0;
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    check("resp_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e_rd = exp_q.pop_front();
                        e_er = exp_err_q.pop_front();
                        e_cy = exp_cyc_q.pop_front();
                        check("resp_rdata", resp_rdata, e_rd);
                        check("resp_err", 32'(resp_err), 32'(e_er));
                        check("resp_latency", 32'(cyc), 32'(e_cy + LAT));
                    end
                    h_rdata = resp_rdata;
                    h_err   = resp_err;
                    in_resp = 1'b1;
                end else begin
                    check("hold_rdata", resp_rdata, h_rdata);
                    check("hold_err", 32'(resp_err), 32'(h_err));
                end
                check("resp_req_ready", 32'(req_ready), 32'd0);
                if (resp_ready) begin
                    in_resp   = 1'b0;
                    chk_after = 1'b1;
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin
                model_accept(w, a, d, s, cyc + 1);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !resp_valid && !in_resp) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic z_issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_er);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        z_valid = 1'b1; z_write = w; z_addr = a; z_wdata = d; z_wstrb = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (z_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("z_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        z_valid = 1'b0;
        @(negedge clk);
        check("z_resp_valid_t1", 32'(z_resp_valid), 32'd1);
        check("z_rdata", z_rdata, exp_rd);
        check("z_err", 32'(z_err), 32'(exp_er));
        @(negedge clk);
        check("z_post_valid", 32'(z_resp_valid), 32'd0);
        check("z_post_ready", 32'(z_req_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        int sel;
        int z_acc;
        bit ok;

        model_clear();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_z_state", 32'(z_dbg), 32'd0);
        @(negedge clk);
        check("first_req_ready", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // Directed: store/load, byte merge, errors
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        issue(1'b1, 32'h20, 32'h11223344, 4'b0101);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        issue(1'b1, 32'hFC, 32'h55667788, 4'hF);
        issue(1'b0, 32'h13, 32'h0, 4'h0);
        issue(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
        issue(1'b0, 32'hFC, 32'h0, 4'h0);
        issue(1'b1, 32'h10, 32'h01020304, 4'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h0000_0110, 32'h9999_9999, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_drain();

        // Backpressure: response held for several cycles
        hold_rr = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("bp_wait_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        hold_rr = 1'b0;
        wait_drain();

        // Randomized traffic
        rr_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, MEM/4 - 1)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, MEM/4 - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'(MEM) + 32'($urandom_range(0, 767));
            else               a = $urandom | 32'h0000_1000;
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        rr_rand = 1'b0;
        wait_drain();

        // Reset while a store is waiting: store is dropped, storage cleared
        issue(1'b1, 32'h08, 32'h12345678, 4'hF);
        reset = 1'b1;
        model_clear();
        in_resp   = 1'b0;
        chk_after = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(1'b0, 32'h08, 32'h0, 4'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_drain();

        // Zero-latency instance
        z_issue(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        z_issue(1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        z_issue(1'b0, 32'h41, 32'h0, 4'h0, 32'h0, 1'b1);
        z_issue(1'b1, 32'h200, 32'h1, 4'hF, 32'h0, 1'b1);
        // Back-to-back: request held valid, acceptances every few cycles
        @(posedge clk); #1;
        z_valid = 1'b1; z_write = 1'b0; z_addr = 32'h40;
        z_acc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (z_req_ready) z_acc++;
        end
        @(posedge clk); #1;
        z_valid = 1'b0;
        check("z_b2b_rate", 32'(z_acc >= 4), 32'd1);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
